branch_sequencer: RTL and testbench
===================================

Name: branch_sequencer

Overview:
- Consumer side of the branch comparator.
- Holds the program counter and takes branch requests from decode. It samples the comparator's equality result one cycle after a branch is accepted, then either redirects the PC and flushes or falls through.
- Sits between decode, branchcomp and instruction fetch in the picoNISC core. Replaces the ad-hoc PC register.

Parameters:
- PC_WIDTH, 8, width of the program counter and branch target.
- RESET_PC, 0, PC value loaded on reset (PC_WIDTH bits).
- PC_INC, 1, increment applied on sequential advance.

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- nReset, input, 1, asynchronous active-low reset.
- enable, input, 1, fetch advance permitted this cycle; only sampled in FETCH.
- br_valid, input, 1, decode presents a branch this cycle; only sampled in FETCH with enable=1.
- br_type, input, 2, 00=JMP (unconditional), 01=BEQ, 10=BNE, 11=reserved.
- br_target, input, PC_WIDTH, absolute branch target.
- cmp_result, input, 1, branchcomp output (1 = operands equal); sampled in RESOLVE only.
- pc, output, PC_WIDTH, current program counter (registered).
- flush, output, 1, squash the fetched/decoded instruction; registered.
- busy, output, 1, sequencer is resolving a branch; decode must hold.

Behaviour:
- Reset (nReset=0, asynchronous):
  - pc=RESET_PC, flush=0, busy=0, state=FETCH.
  - The captured type/target registers clear to 0.
  - Reset in any state, including mid-resolve, abandons the branch with no flush.
- FSM has three states: FETCH, RESOLVE, REDIRECT. busy=1 whenever state != FETCH. flush=1 only in REDIRECT.
- FETCH:
  - enable=0: pc holds; br_valid ignored.
  - enable=1, br_valid=0: pc <= pc + PC_INC, modulo 2^PC_WIDTH. All-ones + 1 wraps to 0.
  - enable=1, br_valid=1: capture br_type and br_target, pc holds, next state RESOLVE.
- RESOLVE (exactly one cycle):
  - Sample cmp_result.
  - taken = (type==00) | (type==01 & cmp_result) | (type==10 & ~cmp_result). Reserved type 11 is never taken.
  - Taken: pc <= captured target, next state REDIRECT.
  - Not taken: pc <= pc + PC_INC, next state FETCH, no flush.
  - enable and br_valid are ignored in this state.
- REDIRECT (exactly one cycle): flush=1, pc holds at target, next state FETCH. Inputs are ignored.
- Latency:
  - Taken branch: 3 cycles from acceptance to the next FETCH at the target, with flush asserted in cycle 2.
  - Not-taken branch: 2 cycles.
- A branch whose target equals the current pc is legal: it redirects to itself and flushes normally.
- A back-to-back branch, with br_valid held high across RESOLVE/REDIRECT, is only accepted on the next FETCH cycle with enable=1.
- X on cmp_result in RESOLVE is a bench error. No X may reach pc.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined: adds two outputs, each 16 bits.
  - resolved_count: increments on every RESOLVE cycle.
  - taken_count: increments on every RESOLVE cycle where taken=1.
  - Both saturate at 16'hFFFF and do not wrap.
  - Both reset to 0 on nReset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then enable=1 for 4 cycles, no branches -> pc 0,1,2,3,4; flush=0 and busy=0 throughout.
- pc=5, br_valid=1, br_type=01, br_target=8'h20, cmp_result=1 in RESOLVE:
  - busy=1 for 2 cycles; flush=1 exactly one cycle.
  - pc=8'h20 on return to FETCH.
  - (STATS) taken_count=1, resolved_count=1.
- pc=5, BNE, target=8'h20, cmp_result=1 -> not taken; pc=6 after 2 cycles, flush never asserted, busy=1 for one cycle.
- PC_WIDTH=8, pc=8'hFF, enable=1, no branch -> pc=8'h00. JMP with target 8'hFF from 8'hFF -> pc stays 8'hFF, flush pulses once.
- nReset asserted while in RESOLVE for a taken JMP to 8'h40 -> pc=RESET_PC immediately, flush=0, busy=0; no redirect after release.
- br_type=11 with cmp_result=0 and then 1 -> never taken, pc advances by PC_INC. enable=0 with br_valid=1 in FETCH -> no capture, pc holds.

Source files
------------

// File: rtl/branch_sequencer.sv
// ============================================================================
// branch_sequencer
// ----------------------------------------------------------------------------
// Holds the program counter for the picoNISC core and runs the consumer side
// of the branch comparator. It accepts a branch request from decode and
// samples the comparator's equality result one cycle later. It then either
// redirects the PC to the captured target with a one-cycle flush, or falls
// through to the next sequential PC.
//
// Ports:
//   clock          in   1          system clock, rising edge
//   nReset         in   1          asynchronous active-low reset
//   enable         in   1          fetch advance permitted (FETCH only)
//   br_valid       in   1          branch presented by decode (FETCH, enable=1)
//   br_type        in   2          00=JMP 01=BEQ 10=BNE 11=reserved (never taken)
//   br_target      in   PC_WIDTH   absolute branch target
//   cmp_result     in   1          comparator equality, sampled in RESOLVE
//   pc             out  PC_WIDTH   registered program counter
//   flush          out  1          registered squash strobe (REDIRECT only)
//   busy           out  1          registered, high while resolving a branch
//   resolved_count out  16         (BRANCH_STATS_EN) saturating RESOLVE count
//   taken_count    out  16         (BRANCH_STATS_EN) saturating taken count
//
// Optional feature macro: BRANCH_STATS_EN adds the two statistics outputs.
// ============================================================================
module branch_sequencer #(
    parameter int                     PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = {PC_WIDTH{1'b0}},
    parameter int                     PC_INC   = 1
) (
    input  logic                clock,
    input  logic                nReset,
    input  logic                enable,
    input  logic                br_valid,
    input  logic [1:0]          br_type,
    input  logic [PC_WIDTH-1:0] br_target,
    input  logic                cmp_result,
    output logic [PC_WIDTH-1:0] pc,
    output logic                flush,
    output logic                busy
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]         resolved_count,
    output logic [15:0]         taken_count
`endif
);

    typedef enum logic [1:0] {
        ST_FETCH    = 2'b00,
        ST_RESOLVE  = 2'b01,
        ST_REDIRECT = 2'b10
    } state_t;

    localparam logic [PC_WIDTH-1:0] W_PC_INC = PC_WIDTH'(PC_INC);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   w_pc_nxt;
    logic [PC_WIDTH-1:0]   r_target;
    logic [PC_WIDTH-1:0]   w_target_nxt;
    logic [1:0]            r_type;
    logic [1:0]            w_type_nxt;
    logic                  r_flush;
    logic                  w_flush_nxt;
    logic                  r_busy;
    logic                  w_busy_nxt;
    logic                  w_taken;

    // Branch decision. The reserved encoding falls to the default arm, so it
    // is never taken.
    function automatic logic branch_taken(input logic [1:0] br_kind,
                                          input logic       equal);
        logic taken;
        case (br_kind)
            2'b00:   taken = 1'b1;
            2'b01:   taken = equal;
            2'b10:   taken = ~equal;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // Next-state, next-PC and branch-capture logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_target_nxt = r_target;
        w_type_nxt   = r_type;
        w_taken      = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (enable) begin
                    if (br_valid) begin
                        // Hold the PC while the comparator settles.
                        w_type_nxt   = br_type;
                        w_target_nxt = br_target;
                        w_state_nxt  = ST_RESOLVE;
                    end else begin
                        w_pc_nxt = r_pc + W_PC_INC;
                    end
                end else begin
                    w_pc_nxt = r_pc;
                end
            end
            ST_RESOLVE: begin
                w_taken = branch_taken(r_type, cmp_result);
                if (w_taken) begin
                    w_pc_nxt    = r_target;
                    w_state_nxt = ST_REDIRECT;
                end else begin
                    w_pc_nxt    = r_pc + W_PC_INC;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_REDIRECT: begin
                w_state_nxt = ST_FETCH;
            end
            default: begin
                // An unreachable encoding recovers to FETCH without a flush.
                w_state_nxt = ST_FETCH;
            end
        endcase
        // busy and flush are registered from the next state so that they
        // line up with the state they describe.
        w_busy_nxt  = (w_state_nxt != ST_FETCH);
        w_flush_nxt = (w_state_nxt == ST_REDIRECT);
    end

    // State, PC, captured branch and registered strobes.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_state  <= ST_FETCH;
            r_pc     <= RESET_PC;
            r_target <= {PC_WIDTH{1'b0}};
            r_type   <= 2'b00;
            r_flush  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_target <= w_target_nxt;
            r_type   <= w_type_nxt;
            r_flush  <= w_flush_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign pc    = r_pc;
    assign flush = r_flush;
    assign busy  = r_busy;

`ifdef BRANCH_STATS_EN
    logic [15:0] r_resolved_cnt;
    logic [15:0] r_taken_cnt;

    // Saturating resolution statistics; both stick at all-ones.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_resolved_cnt <= 16'h0000;
            r_taken_cnt    <= 16'h0000;
        end else begin
            if ((r_state == ST_RESOLVE) && (r_resolved_cnt != 16'hFFFF)) begin
                r_resolved_cnt <= r_resolved_cnt + 16'h0001;
            end else begin
                r_resolved_cnt <= r_resolved_cnt;
            end
            if ((r_state == ST_RESOLVE) && w_taken && (r_taken_cnt != 16'hFFFF)) begin
                r_taken_cnt <= r_taken_cnt + 16'h0001;
            end else begin
                r_taken_cnt <= r_taken_cnt;
            end
        end
    end

    assign resolved_count = r_resolved_cnt;
    assign taken_count    = r_taken_cnt;
`else
    // Statistics disabled: no counters and no statistics ports.
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
module tb_branch_sequencer;

    localparam int PC_W   = 8;
    localparam int PC_INC = 1;
    localparam int PC_MOD = 256;

    logic       clock;
    logic       nReset;
    logic       enable;
    logic       br_valid;
    logic [1:0] br_type;
    logic [7:0] br_target;
    logic       cmp_result;
    logic [7:0] pc;
    logic       flush;
    logic       busy;
`ifdef BRANCH_STATS_EN
    logic [15:0] resolved_count;
    logic [15:0] taken_count;
`endif

    int total;
    int bad;

    branch_sequencer #(.PC_WIDTH(PC_W), .RESET_PC(8'h00), .PC_INC(PC_INC)) dut (
        .clock      (clock),
        .nReset     (nReset),
        .enable     (enable),
        .br_valid   (br_valid),
        .br_type    (br_type),
        .br_target  (br_target),
        .cmp_result (cmp_result),
        .pc         (pc),
        .flush      (flush),
        .busy       (busy)
`ifdef BRANCH_STATS_EN
        ,
        .resolved_count (resolved_count),
        .taken_count    (taken_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply inputs, take one rising edge, settle just after it.
    task automatic cyc(input logic en, input logic v, input logic [1:0] t,
                       input logic [7:0] tg, input logic c);
        enable = en; br_valid = v; br_type = t; br_target = tg; cmp_result = c;
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic       en;
        logic       v;
        logic [1:0] t;
        logic [7:0] tg;
        logic       c;
        logic [7:0] pc;
        logic       fl;
        logic       bz;
    } vec_t;

    typedef struct {
        logic cmp;
        int   pc;
        logic fl;
        logic bz;
    } fut_t;

    vec_t tbl[25];
    fut_t fq[$];

    initial begin : main
        int   m_pc;
        int   m_res;
        int   m_tak;
        int   n;
        logic en;
        logic v;
        logic [1:0] t;
        logic [7:0] tg;
        logic c;
        logic cc;
        bit   tk;
        int   e_pc;
        logic e_fl;
        logic e_bz;
        fut_t f;

        total = 0;
        bad   = 0;

        //               en    v     t      tg     c     pc     fl    bz
        tbl[0]  = '{1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 8'h02, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 8'h03, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 8'h04, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 8'h05, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 2'b01, 8'h20, 1'b0, 8'h05, 1'b0, 1'b1}; // BEQ accept
        tbl[6]  = '{1'b1, 1'b1, 2'b00, 8'h33, 1'b1, 8'h20, 1'b1, 1'b1}; // equal -> taken
        tbl[7]  = '{1'b1, 1'b1, 2'b00, 8'h33, 1'b0, 8'h20, 1'b0, 1'b0}; // redirect, br ignored
        tbl[8]  = '{1'b0, 1'b1, 2'b00, 8'h33, 1'b0, 8'h20, 1'b0, 1'b0}; // enable=0: no capture
        tbl[9]  = '{1'b1, 1'b1, 2'b10, 8'h50, 1'b0, 8'h20, 1'b0, 1'b1}; // BNE accept
        tbl[10] = '{1'b1, 1'b0, 2'b00, 8'h00, 1'b1, 8'h21, 1'b0, 1'b0}; // equal -> not taken
        tbl[11] = '{1'b1, 1'b1, 2'b11, 8'h60, 1'b0, 8'h21, 1'b0, 1'b1}; // reserved
        tbl[12] = '{1'b1, 1'b1, 2'b00, 8'h60, 1'b0, 8'h22, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 2'b11, 8'h60, 1'b0, 8'h22, 1'b0, 1'b1}; // reserved
        tbl[14] = '{1'b1, 1'b1, 2'b00, 8'h60, 1'b1, 8'h23, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 2'b01, 8'h70, 1'b0, 8'h23, 1'b0, 1'b1}; // BEQ accept
        tbl[16] = '{1'b1, 1'b1, 2'b00, 8'h70, 1'b0, 8'h24, 1'b0, 1'b0}; // unequal -> not taken
        tbl[17] = '{1'b1, 1'b1, 2'b00, 8'hFF, 1'b0, 8'h24, 1'b0, 1'b1}; // JMP accept
        tbl[18] = '{1'b1, 1'b1, 2'b00, 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b1};
        tbl[19] = '{1'b1, 1'b1, 2'b00, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0}; // held br ignored
        tbl[20] = '{1'b1, 1'b1, 2'b00, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b1}; // JMP to self
        tbl[21] = '{1'b1, 1'b1, 2'b00, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1};
        tbl[22] = '{1'b0, 1'b1, 2'b00, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0};
        tbl[23] = '{1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0}; // wrap
        tbl[24] = '{1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0};

        // Reset
        nReset = 1'b0;
        enable = 1'b0; br_valid = 1'b0; br_type = 2'b00; br_target = 8'h00; cmp_result = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_pc", pc, 0);
        chk("reset_flush", flush, 0);
        chk("reset_busy", busy, 0);
`ifdef BRANCH_STATS_EN
        chk("reset_resolved", resolved_count, 0);
        chk("reset_taken", taken_count, 0);
`endif
        chk("reset_pc_initial", pc, 0);
        nReset = 1'b1;

        // Directed table
        for (int i = 0; i < 25; i++) begin
            cyc(tbl[i].en, tbl[i].v, tbl[i].t, tbl[i].tg, tbl[i].c);
            chk($sformatf("tbl%0d_pc", i), pc, tbl[i].pc);
            chk($sformatf("tbl%0d_flush", i), flush, tbl[i].fl);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bz);
        end
`ifdef BRANCH_STATS_EN
        chk("tbl_resolved", resolved_count, 7);
        chk("tbl_taken", taken_count, 3);
`endif

        // Reset in the middle of resolving a taken JMP
        cyc(1'b1, 1'b1, 2'b00, 8'h40, 1'b0);
        chk("midrst_accept_busy", busy, 1);
        nReset = 1'b0;
        #1;
        chk("midrst_pc", pc, 0);
        chk("midrst_flush", flush, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clock);
        #1;
        nReset = 1'b1;
        cyc(1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
        chk("midrst_after_pc", pc, 0);
        chk("midrst_after_flush", flush, 0);
        chk("midrst_after_busy", busy, 0);
`ifdef BRANCH_STATS_EN
        chk("midrst_resolved", resolved_count, 0);
        chk("midrst_taken", taken_count, 0);
`endif

        // Randomized run against a timeline model of future outputs
        m_pc  = 0;
        m_res = 0;
        m_tak = 0;
        n     = 0;
        while ((n < 600) && ((n < 400) || (fq.size() != 0))) begin
            en = ($urandom_range(0, 3) != 0);
            v  = ($urandom_range(0, 2) == 0);
            t  = 2'($urandom);
            tg = 8'($urandom);
            c  = 1'($urandom);
            if (fq.size() != 0) begin
                f    = fq.pop_front();
                c    = f.cmp;
                e_pc = f.pc;
                e_fl = f.fl;
                e_bz = f.bz;
            end else if (en && v) begin
                cc = 1'($urandom);
                tk = (t == 2'b00) || ((t == 2'b01) && cc) || ((t == 2'b10) && !cc);
                e_pc = m_pc;
                e_fl = 1'b0;
                e_bz = 1'b1;
                m_res++;
                if (tk) begin
                    m_tak++;
                    fq.push_back('{cc, int'(tg), 1'b1, 1'b1});
                    fq.push_back('{1'b0, int'(tg), 1'b0, 1'b0});
                end else begin
                    fq.push_back('{cc, (m_pc + PC_INC) % PC_MOD, 1'b0, 1'b0});
                end
            end else begin
                e_pc = en ? ((m_pc + PC_INC) % PC_MOD) : m_pc;
                e_fl = 1'b0;
                e_bz = 1'b0;
            end
            m_pc = e_pc;
            cyc(en, v, t, tg, c);
            chk("rnd_pc", pc, e_pc);
            chk("rnd_flush", flush, e_fl);
            chk("rnd_busy", busy, e_bz);
            n++;
        end
        chk("rnd_drained", fq.size(), 0);
`ifdef BRANCH_STATS_EN
        chk("rnd_resolved", resolved_count, m_res);
        chk("rnd_taken", taken_count, m_tak);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
